// File: rtl/pc_gen.sv
// Fetch PC generator: boot sequencing, next-PC selection and early jump adder.
// Optional redirect/exception counters under LEN5_PCGEN_REDIRECT_CNT_EN.
module pc_gen #(
    parameter int unsigned          XLEN       = 64,
    parameter logic [XLEN-1:0]      BOOT_PC    = '0,
    parameter int unsigned          ILEN_BYTES = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            comm_except_raised_i,
    input  logic [XLEN-1:0] comm_except_pc_i,
    input  logic            bu_res_valid_i,
    input  logic            bu_mispredict_i,
    input  logic [XLEN-1:0] bu_res_target_i,
    input  logic            bpu_taken_i,
    input  logic [XLEN-1:0] bpu_target_i,
    input  logic            early_jump_valid_i,
    input  logic [XLEN-1:0] early_jump_base_i,
    input  logic [XLEN-1:0] early_jump_offs_i,
    output logic [XLEN-1:0] early_jump_target_o,
    input  logic            mem_ready_i,
    output logic            mem_valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pred_pc_o,
    output logic [XLEN-1:0] pred_target_o,
    output logic            pred_taken_o,
`ifdef LEN5_PCGEN_REDIRECT_CNT_EN
    output logic [31:0]     redirect_cnt_o,
    output logic [31:0]     except_cnt_o,
`endif
    output logic            redirect_o
);

    typedef enum logic [1:0] {
        RESET = 2'd0,
        BOOT  = 2'd1,
        RUN   = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
        logic            taken;
    } prediction_t;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] PC_INC     = XLEN'(ILEN_BYTES);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            except_redir;
    prediction_t     pred;

    assign early_jump_target_o = early_jump_base_i + early_jump_offs_i;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        mem_valid_o  = 1'b0;
        redirect_o   = 1'b0;
        except_redir = 1'b0;
        case (state_q)
            RESET: state_d = BOOT;
            BOOT:  state_d = RUN;
            RUN: begin
                mem_valid_o = 1'b1;
                // redirects win even without a handshake; request is dropped
                if (comm_except_raised_i) begin
                    pc_d         = comm_except_pc_i & ALIGN_MASK;
                    redirect_o   = 1'b1;
                    except_redir = 1'b1;
                end else if (bu_res_valid_i && bu_mispredict_i) begin
                    pc_d       = bu_res_target_i & ALIGN_MASK;
                    redirect_o = 1'b1;
                end else if (early_jump_valid_i) begin
                    pc_d       = early_jump_target_o & ALIGN_MASK;
                    redirect_o = 1'b1;
                end else if (mem_ready_i && bpu_taken_i) begin
                    pc_d = bpu_target_i & ALIGN_MASK;
                end else if (mem_ready_i) begin
                    pc_d = (pc_q + PC_INC) & ALIGN_MASK;
                end
            end
            default: state_d = RESET;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RESET;
            pc_q    <= BOOT_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign pred = '{pc: pc_q, target: bpu_target_i, taken: bpu_taken_i};

    assign pc_o          = pc_q;
    assign pred_pc_o     = pred.pc;
    assign pred_target_o = pred.target;
    assign pred_taken_o  = pred.taken;

`ifdef LEN5_PCGEN_REDIRECT_CNT_EN
    logic [31:0] redir_cnt_q, exc_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            redir_cnt_q <= '0;
            exc_cnt_q   <= '0;
        end else begin
            if (redirect_o && (redir_cnt_q != '1))
                redir_cnt_q <= redir_cnt_q + 32'd1;
            if (except_redir && (exc_cnt_q != '1))
                exc_cnt_q <= exc_cnt_q + 32'd1;
        end
    end

    assign redirect_cnt_o = redir_cnt_q;
    assign except_cnt_o   = exc_cnt_q;
`else
    logic unused_except;
    assign unused_except = except_redir;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic
// against a cycle-level behavioural model of the fetch PC sequence.
module tb_pc_gen;

    localparam logic [63:0] BOOT = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex;
    logic [63:0] ex_pc;
    logic        bv, bm;
    logic [63:0] bu_tgt;
    logic        bt;
    logic [63:0] bt_tgt;
    logic        ej;
    logic [63:0] ej_base, ej_offs;
    logic [63:0] ej_tgt;
    logic        ready;
    logic        mem_valid;
    logic [63:0] pc;
    logic [63:0] p_pc, p_tgt;
    logic        p_taken;
    logic        redirect;
`ifdef LEN5_PCGEN_REDIRECT_CNT_EN
    logic [31:0] rcnt, ecnt;
`endif

    int checks = 0;
    int errors = 0;

    int          m_cyc;
    logic [63:0] m_pc;
    longint unsigned m_rcnt, m_ecnt;

    always #5 clk = ~clk;

    pc_gen #(.BOOT_PC(BOOT)) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .comm_except_raised_i(ex),
        .comm_except_pc_i    (ex_pc),
        .bu_res_valid_i      (bv),
        .bu_mispredict_i     (bm),
        .bu_res_target_i     (bu_tgt),
        .bpu_taken_i         (bt),
        .bpu_target_i        (bt_tgt),
        .early_jump_valid_i  (ej),
        .early_jump_base_i   (ej_base),
        .early_jump_offs_i   (ej_offs),
        .early_jump_target_o (ej_tgt),
        .mem_ready_i         (ready),
        .mem_valid_o         (mem_valid),
        .pc_o                (pc),
        .pred_pc_o           (p_pc),
        .pred_target_o       (p_tgt),
        .pred_taken_o        (p_taken),
`ifdef LEN5_PCGEN_REDIRECT_CNT_EN
        .redirect_cnt_o      (rcnt),
        .except_cnt_o        (ecnt),
`endif
        .redirect_o          (redirect)
    );

    task automatic cmp(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic exp_running();
        return rst_n && (m_cyc >= 2);
    endfunction

    function automatic logic exp_redirect();
        return exp_running() && (ex || (bv && bm) || ej);
    endfunction

    task automatic check_model();
        cmp("mem_valid", {63'd0, mem_valid}, {63'd0, exp_running()});
        cmp("pc", pc, m_pc);
        cmp("pred_pc", p_pc, m_pc);
        cmp("pred_taken", {63'd0, p_taken}, {63'd0, bt});
        cmp("pred_target", p_tgt, bt_tgt);
        cmp("ej_target", ej_tgt, ej_base + ej_offs);
        cmp("redirect", {63'd0, redirect}, {63'd0, exp_redirect()});
`ifdef LEN5_PCGEN_REDIRECT_CNT_EN
        cmp("redirect_cnt", {32'd0, rcnt}, m_rcnt);
        cmp("except_cnt", {32'd0, ecnt}, m_ecnt);
`endif
    endtask

    task automatic model_reset();
        m_cyc  = 0;
        m_pc   = BOOT;
        m_rcnt = 0;
        m_ecnt = 0;
    endtask

    task automatic update_model();
        logic [63:0] n;
        if (!rst_n) begin
            model_reset();
        end else if (m_cyc < 2) begin
            m_cyc++;
        end else begin
            if (exp_redirect()) begin
                if (m_rcnt < 64'hFFFF_FFFF) m_rcnt++;
                if (ex && m_ecnt < 64'hFFFF_FFFF) m_ecnt++;
            end
            n = m_pc;
            if (ex)               n = ex_pc & ~64'd3;
            else if (bv && bm)    n = bu_tgt & ~64'd3;
            else if (ej)          n = (ej_base + ej_offs) & ~64'd3;
            else if (ready && bt) n = bt_tgt & ~64'd3;
            else if (ready)       n = (m_pc + 64'd4) & ~64'd3;
            m_pc = n;
        end
    endtask

    // entered just after a falling edge with inputs already driven
    task automatic step();
        #2 check_model();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic idle();
        ex = 0; ex_pc = '0; bv = 0; bm = 0; bu_tgt = '0;
        bt = 0; bt_tgt = '0; ej = 0; ej_base = '0; ej_offs = '0;
    endtask

    task automatic hold_reset();
        rst_n = 0;
        model_reset();
        #1 cmp("rst_pc", pc, BOOT);
        cmp("rst_valid", {63'd0, mem_valid}, 64'd0);
        cmp("rst_redirect", {63'd0, redirect}, 64'd0);
        step();
        step();
        rst_n = 1;
    endtask

    initial begin
        idle();
        ready = 1;
        rst_n = 0;
        model_reset();
        @(negedge clk);
        hold_reset();

        step();
        cmp("boot_idle", {63'd0, mem_valid}, 64'd0);
        step();
        cmp("first_valid", {63'd0, mem_valid}, 64'd1);
        cmp("first_pc", pc, 64'h8000_0000);
        step();
        cmp("seq_pc1", pc, 64'h8000_0004);
        step();
        cmp("seq_pc2", pc, 64'h8000_0008);
        step();
        step();
        cmp("pc_10", pc, 64'h8000_0010);

        ready = 0;
        repeat (3) begin
            step();
            cmp("stall_pc", pc, 64'h8000_0010);
            cmp("stall_valid", {63'd0, mem_valid}, 64'd1);
        end
        ready = 1;
        step();
        cmp("resume_pc", pc, 64'h8000_0014);
        repeat (3) step();
        cmp("pc_20", pc, 64'h8000_0020);

        bt = 1; bt_tgt = 64'h8000_0100;
        #1 cmp("bpu_no_redirect", {63'd0, redirect}, 64'd0);
        step();
        cmp("bpu_pc", pc, 64'h8000_0100);

        idle();
        ready = 0; ej = 1;
        ej_base = 64'h8000_0040; ej_offs = 64'hFFFF_FFFF_FFFF_FFF0;
        #1 cmp("ej_sum", ej_tgt, 64'h8000_0030);
        cmp("ej_redirect", {63'd0, redirect}, 64'd1);
        step();
        cmp("ej_pc", pc, 64'h8000_0030);

        ex = 1; ex_pc = 64'h100;
        bv = 1; bm = 1; bu_tgt = 64'h200;
        ej = 1; ej_base = 64'h300; ej_offs = '0;
        step();
        cmp("prio_except", pc, 64'h100);
        ex = 0; ej = 0;
        step();
        cmp("prio_mispredict", pc, 64'h200);
        idle();
        ready = 1;

        hold_reset();
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            idle();
            case (i)
                0, 3: begin ex = 1; ex_pc = 64'h1000 + 64'(i * 64); end
                1: begin ej = 1; ej_base = 64'h2000; ej_offs = 64'h22; end
                default: begin bv = 1; bm = 1; bu_tgt = 64'h3003; end
            endcase
            step();
        end
        idle();
`ifdef LEN5_PCGEN_REDIRECT_CNT_EN
        cmp("cnt_redirect5", {32'd0, rcnt}, 64'd5);
        cmp("cnt_except2", {32'd0, ecnt}, 64'd2);
`endif
        step();
        rst_n = 0;
        model_reset();
        #1 cmp("midrst_pc", pc, BOOT);
        cmp("midrst_valid", {63'd0, mem_valid}, 64'd0);
`ifdef LEN5_PCGEN_REDIRECT_CNT_EN
        cmp("midrst_rcnt", {32'd0, rcnt}, 64'd0);
        cmp("midrst_ecnt", {32'd0, ecnt}, 64'd0);
`endif
        step();
        rst_n = 1;

        for (int c = 0; c < 3000; c++) begin
            ex      = ($urandom_range(0, 15) == 0);
            ex_pc   = {$urandom, $urandom};
            bv      = ($urandom_range(0, 3) == 0);
            bm      = $urandom_range(0, 1) == 1;
            bu_tgt  = {$urandom, $urandom};
            bt      = ($urandom_range(0, 3) == 0);
            bt_tgt  = {$urandom, $urandom};
            ej      = ($urandom_range(0, 9) == 0);
            ej_base = {$urandom, $urandom};
            ej_offs = {$urandom, $urandom};
            ready   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 0;
                model_reset();
            end else begin
                rst_n = 1;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Program-counter generation stage; sits directly upstream of the instruction memory interface and the early jump decoder.
- Holds the fetch PC and drives it to memory with a valid/ready handshake.
- Selects the next PC among commit exception, branch-unit misprediction, early jump redirect, branch-predictor guess, and sequential increment.
- Computes the early jump target adder result consumed back by the early jump decoder.

Parameters:
- BOOT_PC, 64'h0, PC loaded at reset and driven on the first fetch.
- XLEN, len5_pkg::XLEN (64), PC/target width.
- ILEN_BYTES, 4, sequential increment in bytes.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- comm_except_raised_i  in  1  commit unit requests exception/trap redirect
- comm_except_pc_i  in  XLEN  trap handler target
- bu_res_valid_i  in  1  branch unit resolution valid
- bu_mispredict_i  in  1  resolved branch was mispredicted (qualified by bu_res_valid_i)
- bu_res_target_i  in  XLEN  correct target on mispredict
- bpu_taken_i  in  1  predictor says current pc_o is a taken branch
- bpu_target_i  in  XLEN  predicted target for current pc_o
- early_jump_valid_i  in  1  early jump decoder redirect request
- early_jump_base_i  in  XLEN  adder operand A
- early_jump_offs_i  in  XLEN  adder operand B
- early_jump_target_o  out  XLEN  base+offs, returned to the early jump decoder
- mem_ready_i  in  1  memory interface accepts request
- mem_valid_o  out  1  fetch request valid
- pc_o  out  XLEN  fetch PC
- pred_pc_o / pred_target_o / pred_taken_o  out  XLEN/XLEN/1  prediction_t fields forwarded with the fetch
- redirect_o  out  1  pulse: PC was redirected this cycle (non-sequential, non-BPU)

Behaviour:
- Clock is clk_i; reset is asynchronous, active-low on rst_ni.
- Reset values:
  - state = RESET, pc_q = BOOT_PC, mem_valid_o = 0, redirect_o = 0.
  - early_jump_target_o is combinational and not reset.
- FSM:
  - RESET -> BOOT unconditionally; mem_valid_o = 0.
  - BOOT -> RUN; mem_valid_o = 0 (one idle cycle so memory settles).
  - RUN: mem_valid_o = 1 permanently. Stays in RUN.
  - Net effect: first valid request appears 2 cycles after reset deassertion, with pc_o = BOOT_PC.
- early_jump_target_o = early_jump_base_i + early_jump_offs_i, modulo 2^XLEN, purely combinational, zero latency.
- Next PC, strict priority, evaluated every cycle in RUN:
  1. comm_except_raised_i -> comm_except_pc_i
  2. bu_res_valid_i & bu_mispredict_i -> bu_res_target_i
  3. early_jump_valid_i -> early_jump_target_o
  4. mem_valid_o & mem_ready_i & bpu_taken_i -> bpu_target_i
  5. mem_valid_o & mem_ready_i -> pc_q + ILEN_BYTES (wraps mod 2^XLEN)
  6. otherwise hold pc_q
- Redirects (cases 1-3):
  - Take effect on the next edge regardless of mem_ready_i.
  - The unaccepted current request is dropped; downstream flushing is the responsibility of other stages.
  - redirect_o = 1 in that same cycle (combinational).
- Lower PC bits: next PC bits [1:0] are forced to 0 on every update.
- Handshake: pc_o and the pred_* outputs are stable while mem_valid_o & !mem_ready_i, unless a redirect occurs.
- Prediction outputs:
  - pred_pc_o = pc_q, pred_taken_o = bpu_taken_i, pred_target_o = bpu_target_i.
  - bpu_* are valid for the current pc_o in the same cycle.
- Simultaneous events:
  - Exception beats mispredict; mispredict beats early jump; early jump beats BPU and sequential.
  - A redirect in the same cycle as a handshake discards the handshake's sequential/BPU next PC.
- Redirect inputs received in RESET or BOOT are ignored.
- Reset asserted mid-operation returns immediately to RESET/BOOT_PC.

Optional Feature:
- Macro: LEN5_PCGEN_REDIRECT_CNT_EN.
- When defined:
  - Adds output redirect_cnt_o [31:0].
  - Counter increments on each cycle redirect_o = 1, saturates at 32'hFFFF_FFFF, resets to 0.
  - Adds output except_cnt_o [31:0], same rules, counting case-1 redirects only.
- When undefined: both ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, mem_ready_i = 1 constant, BOOT_PC = 64'h8000_0000 -> mem_valid_o rises 2 cycles after release; pc_o sequence 0x80000000, 0x80000004, 0x80000008.
- mem_ready_i = 0 for 3 cycles at pc 0x80000010 -> pc_o and mem_valid_o held at 0x80000010; advances to 0x80000014 the cycle after ready returns.
- bpu_taken_i = 1, bpu_target_i = 0x80000100, handshake at pc 0x80000020 -> next pc_o = 0x80000100, redirect_o = 0.
- early_jump_valid_i = 1, base = 0x80000040, offs = 0xFFFF_FFFF_FFFF_FFF0 (-16), mem_ready_i = 0 -> early_jump_target_o = 0x80000030; next pc_o = 0x80000030; redirect_o = 1.
- Same cycle: comm_except_raised_i (pc 0x100), bu mispredict (0x200), early jump (0x300) -> next pc_o = 0x100; next cycle mispredict alone -> 0x200.
- With LEN5_PCGEN_REDIRECT_CNT_EN: 5 redirects including 2 exceptions -> redirect_cnt_o = 5, except_cnt_o = 2; rst_ni low mid-run -> both 0 and pc_o = BOOT_PC.
